// File: rtl/lab1_imul_int_mul_arb.sv
// Two requesters share one integer multiplier; a tag FIFO remembers who issued each operation so products route back in order.
// Optional feature: define LAB1_IMUL_INT_MUL_ARB_RR_EN for round-robin arbitration (default build is fixed priority, requester 0 first).
module lab1_imul_int_mul_arb #(
  parameter int unsigned p_depth = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_val,
  output logic        req0_rdy,
  input  logic [63:0] req0_msg,
  input  logic        req1_val,
  output logic        req1_rdy,
  input  logic [63:0] req1_msg,
  output logic        resp0_val,
  input  logic        resp0_rdy,
  output logic [31:0] resp0_msg,
  output logic        resp1_val,
  input  logic        resp1_rdy,
  output logic [31:0] resp1_msg,
  output logic        mul_req_val,
  input  logic        mul_req_rdy,
  output logic [63:0] mul_req_msg,
  input  logic        mul_resp_val,
  output logic        mul_resp_rdy,
  input  logic [31:0] mul_resp_msg
);
  localparam int unsigned PW = (p_depth > 1) ? $clog2(p_depth) : 1;
  localparam int unsigned CW = $clog2(p_depth + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(p_depth);

  logic [p_depth-1:0] tag_q, tag_d;
  logic [PW-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]      count_q, count_d;
  logic               any_val_s, full_s, empty_s, head_tag_s, grant_s, push_s, pop_s;

`ifdef LAB1_IMUL_INT_MUL_ARB_RR_EN
  logic prio_q, prio_d;

  // round-robin grant: prio_q breaks ties
  always_comb begin
    if (req0_val && req1_val) begin
      grant_s = prio_q;
    end else if (req1_val) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
    prio_d = push_s ? ~grant_s : prio_q;
  end
`else
  // fixed-priority grant, requester 0 wins ties
  always_comb begin
    if (req0_val) begin
      grant_s = 1'b0;
    end else if (req1_val) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end
`endif

  // zero-latency handshake routing; reset forces every val/rdy low
  always_comb begin
    any_val_s    = req0_val | req1_val;
    full_s       = (count_q == FULL_CNT);
    empty_s      = (count_q == {CW{1'b0}});
    head_tag_s   = tag_q[head_q];
    mul_req_val  = !reset && any_val_s && !full_s;
    mul_req_msg  = grant_s ? req1_msg : req0_msg;
    req0_rdy     = mul_req_val && !grant_s && mul_req_rdy;
    req1_rdy     = mul_req_val && grant_s && mul_req_rdy;
    resp0_val    = !reset && mul_resp_val && !empty_s && !head_tag_s;
    resp1_val    = !reset && mul_resp_val && !empty_s && head_tag_s;
    resp0_msg    = mul_resp_msg;
    resp1_msg    = mul_resp_msg;
    mul_resp_rdy = !reset && !empty_s && (head_tag_s ? resp1_rdy : resp0_rdy);
    push_s       = mul_req_val && mul_req_rdy;
    pop_s        = mul_resp_val && mul_resp_rdy;
  end

  // tag FIFO next state; pointers wrap naturally since p_depth is a power of two
  always_comb begin
    tag_d         = tag_q;
    tag_d[tail_q] = push_s ? grant_s : tag_q[tail_q];
    tail_d        = push_s ? tail_q + PW'(1) : tail_q;
    head_d        = pop_s ? head_q + PW'(1) : head_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q   <= {p_depth{1'b0}};
      head_q  <= {PW{1'b0}};
      tail_q  <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
`ifdef LAB1_IMUL_INT_MUL_ARB_RR_EN
      prio_q  <= 1'b0;
`endif
    end else begin
      tag_q   <= tag_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
`ifdef LAB1_IMUL_INT_MUL_ARB_RR_EN
      prio_q  <= prio_d;
`endif
    end
  end
endmodule

// File: tb/tb_lab1_imul_int_mul_arb.sv
// Bench for lab1_imul_int_mul_arb: queue-based reference model checked every cycle, directed scenarios with literal expectations, then random traffic.
module tb_lab1_imul_int_mul_arb;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req0_val, req0_rdy, req1_val, req1_rdy;
  logic [63:0] req0_msg, req1_msg, mul_req_msg;
  logic        resp0_val, resp0_rdy, resp1_val, resp1_rdy;
  logic [31:0] resp0_msg, resp1_msg, mul_resp_msg;
  logic        mul_req_val, mul_req_rdy, mul_resp_val, mul_resp_rdy;

  lab1_imul_int_mul_arb #(.p_depth(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_msg(req0_msg),
    .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_msg(req1_msg),
    .resp0_val(resp0_val), .resp0_rdy(resp0_rdy), .resp0_msg(resp0_msg),
    .resp1_val(resp1_val), .resp1_rdy(resp1_rdy), .resp1_msg(resp1_msg),
    .mul_req_val(mul_req_val), .mul_req_rdy(mul_req_rdy), .mul_req_msg(mul_req_msg),
    .mul_resp_val(mul_resp_val), .mul_resp_rdy(mul_resp_rdy), .mul_resp_msg(mul_resp_msg)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // model state: outstanding tags in issue order, expected products per requester, multiplier pipeline
  bit          tags[$];
  bit          prio;
  logic [31:0] exp0[$], exp1[$], mulq[$];
  logic [31:0] rlog0[$], rlog1[$];
  int          glog[$];
  logic [63:0] ops0[$], ops1[$];
  int          idx0, idx1, n_push0, n_push1;
  bit          mul_hold, rand_mode;
  bit          e_grant, e_mreq_val, e_mrr, e_head;
  logic [31:0] e_prod;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hxxxxxxxx;
  endfunction

  task automatic drive();
    if (rand_mode) begin
      req0_val    = ($urandom_range(2) != 0);
      req1_val    = ($urandom_range(2) != 0);
      req0_msg    = {(($urandom_range(7) == 0) ? 32'hFFFFFFFF : $urandom()), $urandom()};
      req1_msg    = {$urandom(), (($urandom_range(7) == 0) ? 32'hFFFFFFFF : $urandom())};
      mul_req_rdy = ($urandom_range(3) != 0);
      resp0_rdy   = ($urandom_range(3) != 0);
      resp1_rdy   = ($urandom_range(3) != 0);
    end else begin
      req0_val = (idx0 < ops0.size());
      req1_val = (idx1 < ops1.size());
      req0_msg = req0_val ? ops0[idx0] : 64'h0;
      req1_msg = req1_val ? ops1[idx1] : 64'h0;
    end
    if (mul_hold) mul_resp_val = 1'b0;
    else if (rand_mode) mul_resp_val = (mulq.size() > 0) ? ($urandom_range(3) != 0) : ($urandom_range(7) == 0);
    else mul_resp_val = (mulq.size() > 0);
    mul_resp_msg = (mulq.size() > 0) ? mulq[0] : $urandom();
  endtask

  // compare every DUT output against what the rules demand for the current inputs and model state
  task automatic check();
    bit full, empty, any;
    logic [63:0] gmsg;
    any   = req0_val | req1_val;
    full  = (tags.size() >= DEPTH);
    empty = (tags.size() == 0);
    e_head = empty ? 1'b0 : tags[0];
`ifdef LAB1_IMUL_INT_MUL_ARB_RR_EN
    e_grant = (req0_val && req1_val) ? prio : (req1_val && !req0_val);
`else
    e_grant = (!req0_val && req1_val);
`endif
    e_mreq_val = !reset && any && !full;
    e_mrr      = !reset && !empty && (e_head ? resp1_rdy : resp0_rdy);
    gmsg       = e_grant ? req1_msg : req0_msg;
    e_prod     = gmsg[63:32] * gmsg[31:0];
    chk("mul_req_val", mul_req_val, e_mreq_val);
    if (e_mreq_val) chk("mul_req_msg", mul_req_msg, gmsg);
    chk("req0_rdy", req0_rdy, e_mreq_val && !e_grant && mul_req_rdy);
    chk("req1_rdy", req1_rdy, e_mreq_val && e_grant && mul_req_rdy);
    chk("resp0_val", resp0_val, !reset && mul_resp_val && !empty && !e_head);
    chk("resp1_val", resp1_val, !reset && mul_resp_val && !empty && e_head);
    chk("mul_resp_rdy", mul_resp_rdy, e_mrr);
    if (mul_resp_val && e_mrr) begin
      if (e_head) chk("resp1_product", resp1_msg, qat(exp1, 0));
      else        chk("resp0_product", resp0_msg, qat(exp0, 0));
    end
    if (resp0_val && resp0_rdy) rlog0.push_back(resp0_msg);
    if (resp1_val && resp1_rdy) rlog1.push_back(resp1_msg);
    if (mul_req_val && mul_req_rdy) glog.push_back(req1_rdy ? 1 : 0);
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      tags.delete(); exp0.delete(); exp1.delete();
      prio = 1'b0;
    end else begin
      if (mul_resp_val && e_mrr) begin
        void'(tags.pop_front());
        if (mulq.size() > 0) void'(mulq.pop_front());
        if (e_head) begin if (exp1.size() > 0) void'(exp1.pop_front()); end
        else begin if (exp0.size() > 0) void'(exp0.pop_front()); end
      end
      if (e_mreq_val && mul_req_rdy) begin
        tags.push_back(e_grant);
        mulq.push_back(e_prod);
        prio = ~e_grant;
        if (e_grant) begin exp1.push_back(e_prod); idx1++; n_push1++; end
        else begin exp0.push_back(e_prod); idx0++; n_push0++; end
      end
    end
    @(negedge clk);
  endtask

  task automatic step_a();
    drive();
    #1;
    check();
  endtask

  task automatic cyc();
    step_a();
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ops0.delete(); ops1.delete();
    idx0 = 0; idx1 = 0;
    cyc(); cyc();
    reset = 1'b0;
    mulq.delete(); rlog0.delete(); rlog1.delete(); glog.delete();
    mul_hold = 1'b0; n_push0 = 0; n_push1 = 0;
    mul_req_rdy = 1'b1; resp0_rdy = 1'b1; resp1_rdy = 1'b1;
  endtask

  initial begin
    int exp_g[6];
    reset = 1'b1; req0_val = 1'b0; req1_val = 1'b0; req0_msg = 64'h0; req1_msg = 64'h0;
    resp0_rdy = 1'b1; resp1_rdy = 1'b1; mul_req_rdy = 1'b1;
    mul_resp_val = 1'b0; mul_resp_msg = 32'h0;
    prio = 1'b0; mul_hold = 1'b0; rand_mode = 1'b0;
    @(negedge clk);
    do_reset();

    // single stream from requester 0
    ops0 = '{{32'd3, 32'd4}, {32'hFFFFFFFF, 32'd2}};
    repeat (8) cyc();
    chk("t040_count0", rlog0.size(), 2);
    chk("t040_first", qat(rlog0, 0), 32'h0000000C);
    chk("t040_second", qat(rlog0, 1), 32'hFFFFFFFE);
    chk("t040_count1", rlog1.size(), 0);

    // contention: both requesters hold val with three operations each
    do_reset();
    ops0 = '{{32'd1, 32'd10}, {32'd2, 32'd10}, {32'd3, 32'd10}};
    ops1 = '{{32'd1, 32'd100}, {32'd2, 32'd100}, {32'd3, 32'd100}};
    repeat (12) cyc();
`ifdef LAB1_IMUL_INT_MUL_ARB_RR_EN
    exp_g = '{0, 1, 0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 1, 1, 1};
`endif
    chk("t041_issues", glog.size(), 6);
    for (int i = 0; i < 6; i++) chk($sformatf("t041_grant%0d", i), (i < glog.size()) ? glog[i] : -1, exp_g[i]);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t041_resp0_%0d", i), qat(rlog0, i), 32'(10 * (i + 1)));
      chk($sformatf("t041_resp1_%0d", i), qat(rlog1, i), 32'(100 * (i + 1)));
    end

    // full: multiplier withholds responses while four operations issue
    do_reset();
    mul_hold = 1'b1;
    for (int i = 0; i < 5; i++) ops0.push_back({32'(i + 1), 32'd7});
    for (int i = 0; i < 6; i++) begin
      step_a();
      chk("t043_rdy_fill", req0_rdy, (i < 4) ? 1 : 0);
      tick();
    end
    mul_hold = 1'b0;
    step_a();
    chk("t043_rdy_pop_cycle", req0_rdy, 0);
    chk("t043_resp_during_full", resp0_val, 1);
    tick();
    step_a();
    chk("t043_rdy_after_pop", req0_rdy, 1);
    tick();
    repeat (8) cyc();
    chk("t043_resp_count", rlog0.size(), 5);
    chk("t043_last", qat(rlog0, 4), 32'd35);

    // head-of-line: tags [0,1], requester 0 stalls its response
    do_reset();
    mul_hold = 1'b1;
    ops0 = '{{32'd5, 32'd6}};
    ops1 = '{{32'd7, 32'd8}};
    repeat (3) cyc();
    mul_hold = 1'b0;
    resp0_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step_a();
      chk("t044_resp0_val", resp0_val, 1);
      chk("t044_resp1_val", resp1_val, 0);
      chk("t044_blocked", mul_resp_rdy, 0);
      tick();
    end
    resp0_rdy = 1'b1;
    step_a();
    chk("t044_head_fire", mul_resp_rdy, 1);
    tick();
    step_a();
    chk("t044_next_val", resp1_val, 1);
    chk("t044_next_msg", resp1_msg, 32'd56);
    tick();
    chk("t044_r0", qat(rlog0, 0), 32'd30);
    chk("t044_r1", qat(rlog1, 0), 32'd56);

    // reset mid-operation with two outstanding operations
    do_reset();
    mul_hold = 1'b1;
    ops0 = '{{32'd2, 32'd3}, {32'd4, 32'd5}};
    repeat (3) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    mul_hold = 1'b0;
    ops0 = '{{32'd9, 32'd9}};
    idx0 = 0;
    step_a();
    chk("t045_late_resp0", resp0_val, 0);
    chk("t045_late_resp1", resp1_val, 0);
    chk("t045_empty", mul_resp_rdy, 0);
    chk("t045_accept", req0_rdy, 1);
    tick();
    // the multiplier drops its stale results, leaving only the fresh one
    void'(mulq.pop_front());
    void'(mulq.pop_front());
    repeat (6) cyc();
    chk("t045_fresh_count", rlog0.size(), 1);
    chk("t045_fresh", qat(rlog0, 0), 32'd81);

    // random traffic
    do_reset();
    rand_mode = 1'b1;
    repeat (3000) cyc();
    rand_mode = 1'b0;
    mul_req_rdy = 1'b1; resp0_rdy = 1'b1; resp1_rdy = 1'b1;
    repeat (20) cyc();
    chk("rand_all_resp0", rlog0.size(), n_push0);
    chk("rand_all_resp1", rlog1.size(), n_push1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
